// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter feeding the write port of the async FIFO.
// Optional macro FIFO_ARB_BURST_LIMIT_EN caps each grant at MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic [N_REQ*DW-1:0]      wdata_in,
  input  logic                     full,
  input  logic                     almost_full,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic                     winc,
  output logic [DW-1:0]            wdata,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [OW-1:0]     owner_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic              busy_nxt;
  logic [OW-1:0]     hi_idx, lo_idx, winner;
  logic              hi_found;
  logic              grant_start;
  logic              beat;
  logic              rel;

  assign grant_start = (state == IDLE) && (|req) && !almost_full;
  assign beat        = (state == GRANT) && req[owner] && !full;

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] beat_cnt;

  assign rel = beat && (last[owner] || (beat_cnt == CW'(MAX_BURST - 1)));

  // Beats accepted in the current grant; cleared while idle and on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if ((state == IDLE) || rel) begin
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + CW'(1);
    end else begin
      beat_cnt <= beat_cnt;
    end
  end
`else
  assign rel = beat && last[owner];
`endif

  // Lowest requesting index at or above rr_ptr wins, otherwise wrap to the lowest below it.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (OW'(j) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = OW'(j);
      end else if (req[j]) begin
        lo_idx = OW'(j);
      end else begin
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      owner  <= owner_nxt;
      busy   <= busy_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant_start ? GRANT : IDLE;
      GRANT:   state_nxt = rel ? IDLE : GRANT;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, plus the combinational write-port strobes.
  always_comb begin
    gnt_nxt    = gnt;
    owner_nxt  = owner;
    busy_nxt   = busy;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (grant_start) begin
          gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
          owner_nxt = winner;
          busy_nxt  = 1'b1;
        end else begin
          gnt_nxt   = '0;
          owner_nxt = '0;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (rel) begin
          gnt_nxt    = '0;
          owner_nxt  = '0;
          busy_nxt   = 1'b0;
          rr_ptr_nxt = (owner == OW'(N_REQ - 1)) ? '0 : owner + OW'(1);
        end else begin
          gnt_nxt    = gnt;
          owner_nxt  = owner;
          busy_nxt   = busy;
        end
      end
      default: begin
        gnt_nxt    = '0;
        owner_nxt  = '0;
        busy_nxt   = 1'b0;
        rr_ptr_nxt = '0;
      end
    endcase

    winc = beat;
    ack  = beat ? gnt : '0;
    if (|gnt) begin
      wdata = wdata_in[owner*DW +: DW];
    end else begin
      wdata = '0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a transaction-level
// round-robin model; honours FIFO_ARB_BURST_LIMIT_EN when defined.
module tb_fifo_wr_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int MAX_B = 4;
`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*DW-1:0] wdata_in;
  logic                full;
  logic                almost_full;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic                winc;
  logic [DW-1:0]       wdata;
  logic [1:0]          owner;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  bit              rec_en   = 1'b0;
  logic [N_REQ-1:0] prev_gnt = '0;
  int              grant_log[$];

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_BURST(MAX_B)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .wdata_in(wdata_in),
    .full(full), .almost_full(almost_full), .gnt(gnt), .ack(ack),
    .winc(winc), .wdata(wdata), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [N_REQ-1:0] e_gnt;
    logic [DW-1:0]    e_wdata;
    bit               e_beat;
    e_gnt   = '0;
    e_wdata = '0;
    if (m_busy) begin
      e_gnt[m_owner] = 1'b1;
      e_wdata        = wdata_in[m_owner*DW +: DW];
    end
    e_beat = m_busy && req[m_owner] && !full;
    check_eq("gnt",   64'(gnt),   64'(e_gnt));
    check_eq("owner", 64'(owner), m_busy ? 64'(m_owner) : 64'd0);
    check_eq("busy",  64'(busy),  64'(m_busy));
    check_eq("winc",  64'(winc),  64'(e_beat));
    check_eq("ack",   64'(ack),   e_beat ? 64'(e_gnt) : 64'd0);
    check_eq("wdata", 64'(wdata), 64'(e_wdata));
    if (rec_en && (gnt != '0) && (prev_gnt == '0)) grant_log.push_back(int'(owner));
    prev_gnt = gnt;
  endtask

  // advance the model by one clock edge using the inputs in force at that edge
  task automatic model_step();
    if (!m_busy) begin
      if ((req != '0) && !almost_full) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (!m_busy && req[(m_ptr + k) % N_REQ]) begin
            m_busy  = 1'b1;
            m_owner = (m_ptr + k) % N_REQ;
            m_cnt   = 0;
          end
        end
      end
    end else if (req[m_owner] && !full) begin
      m_cnt++;
      if (last[m_owner] || (LIMIT && (m_cnt == MAX_B))) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N_REQ;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_gnt",   64'(gnt),   64'd0);
    check_eq("rst_owner", 64'(owner), 64'd0);
    check_eq("rst_busy",  64'(busy),  64'd0);
    check_eq("rst_winc",  64'(winc),  64'd0);
    check_eq("rst_ack",   64'(ack),   64'd0);
    m_busy = 1'b0;
    m_ptr  = 0;
    m_cnt  = 0;
    #1 rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N_REQ; i++) wdata_in[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    rst = 1'b1; req = '0; last = '0; wdata_in = '0; full = 1'b0; almost_full = 1'b0;
    #3;
    compare_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // single requester, three-beat burst
    for (int c = 0; c < 6; c++) begin
      rand_data();
      req  = (c < 4) ? 4'b0001 : 4'b0000;
      last = (c == 3) ? 4'b0001 : 4'b0000;
      step();
    end

    // all requesting single-beat bursts from rr_ptr=0: order 0,1,2,3,0
    pulse_reset();
    rec_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      req = 4'b1111; last = 4'b1111;
      step();
    end
    rec_en = 1'b0;
    check_eq("rr_count", 64'(grant_log.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) check_eq("rr_order", 64'(grant_log[i]), 64'(i % N_REQ));
    end

    // requester 2 stalled by full with last held during the stall
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      rand_data();
      req  = (c < 8) ? 4'b0100 : 4'b0000;
      full = (c >= 3 && c <= 5);
      last = (c >= 3 && c <= 6) ? 4'b0100 : 4'b0000;
      step();
    end

    // almost_full blocks a new grant in IDLE but not a running burst
    for (int c = 0; c < 12; c++) begin
      rand_data();
      req         = 4'b0010;
      almost_full = (c < 3) || (c >= 6);
      last        = (c == 9) ? 4'b0010 : 4'b0000;
      step();
    end
    almost_full = 1'b0; req = '0; last = '0;
    step();

    // reset mid-burst on requester 3, then restart from rr_ptr=0
    pulse_reset();
    req = 4'b1000; last = '0;
    step();
    step();
    pulse_reset();
    req = 4'b1001;
    step();
    step();
    last = 4'b1001;
    step();
    req = '0; last = '0;
    step();

    // requester 0 streams without last while requester 1 waits
    pulse_reset();
    for (int c = 0; c < 24; c++) begin
      rand_data();
      req  = 4'b0011;
      last = (c >= 14 && c < 18) ? 4'b0010 : 4'b0000;
      step();
    end
    req = '0; last = '0;
    step();
    step();

    // randomised traffic with occasional asynchronous reset
    for (int c = 0; c < 2000; c++) begin
      rand_data();
      req         = N_REQ'($urandom);
      last        = N_REQ'($urandom & $urandom);
      full        = ($urandom_range(0, 6) == 0);
      almost_full = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) pulse_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
